cic_comp_fir: RTL and testbench
===============================

CIC_COMP_FIR -- requirements
Module: cic_comp_fir

Interface
REQ-001 Parameter WIDTH, default 16, sample width of input and output; two's-complement signed.
REQ-002 Parameter DECIM, default 1, output decimation ratio; legal values 1 and 2 only.
REQ-003 i_clock  input  1  single clock for all logic.
REQ-004 i_reset  input  1  reset, asynchronous, active-high.
REQ-005 i_in_data  input  WIDTH  sample from the upstream cic_decim o_out_data.
REQ-006 i_in_valid  input  1  single-cycle qualifier for i_in_data; no backpressure exists.
REQ-007 o_out_data  output  WIDTH  compensated, rounded, saturated sample.
REQ-008 o_out_valid  output  1  one-cycle pulse qualifying o_out_data.
REQ-009 o_overrun  output  1  sticky flag; a sample arrived while the MAC was busy.

Function
REQ-010 The block SHALL implement a NUM_TAPS=16 direct-form FIR using coefficients COEF[0..15], signed, COEF_WIDTH=16, Q1.15.
REQ-011 Every accepted sample SHALL shift into a 16-entry delay line: entry 0 takes the new sample; entry k takes the old entry k-1.
REQ-012 A decimation phase counter SHALL advance on every accepted sample; a filter computation starts only when the counter wraps (every sample for DECIM=1, every 2nd for DECIM=2, starting with the 2nd sample after reset).
REQ-013 FSM states: IDLE, MAC, ROUND; reset state IDLE.
REQ-014 IDLE->MAC on an accepted sample that starts a computation; accumulator cleared and tap index set to 0 on that edge.
REQ-015 In MAC, each cycle SHALL add delay[k]*COEF[k] to the accumulator, k=0..15; after k=15, MAC->ROUND.
REQ-016 Accumulator width SHALL be WIDTH+COEF_WIDTH+4 (36 bits for defaults), signed, with no internal overflow possible.
REQ-017 ROUND SHALL add 2^14, arithmetic-shift right by 15, saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1], register to o_out_data, pulse o_out_valid, and return to IDLE.
REQ-018 Latency: o_out_valid SHALL be high for exactly one cycle, NUM_TAPS+2 = 18 rising edges after the edge that accepted the starting sample.
REQ-019 o_out_data SHALL hold its value between pulses.
REQ-020 A sample with i_in_valid=1 while the FSM is in MAC or ROUND SHALL be dropped: no shift and no phase advance. On that edge o_overrun SHALL be set and held until reset.
REQ-021 A sample accepted in IDLE that does not start a computation (DECIM=2, odd phase) SHALL only shift the delay line.
REQ-022 With no accepted samples, o_out_valid SHALL never assert.

Reset
REQ-023 Asserting i_reset SHALL immediately clear o_out_data, o_out_valid, o_overrun, the accumulator, the tap index, the phase counter and all delay-line entries to 0, and force IDLE.
REQ-024 Reset asserted mid-MAC SHALL abort the computation; no o_out_valid from that computation appears after release.
REQ-025 The first sample SHALL be accepted on the first rising edge after i_reset deasserts.

Structure
REQ-026 Package cic_comp_pkg SHALL hold NUM_TAPS, COEF_WIDTH, the COEF constant array, and the FSM state enum typedef.
REQ-027 Round-and-saturate logic SHALL be one sub-module, round_sat, parameterized by input width, output width and shift; all other logic stays in cic_comp_fir.

Verification
REQ-028 No i_in_valid for 2000 cycles after reset -> zero o_out_valid pulses, o_overrun=0.
REQ-029 DECIM=1, impulse 16'h4000 followed by 15 zeros spaced 20 cycles apart -> 16 outputs equal to round(COEF[k]/2), k=0..15, each 18 edges after its input.
REQ-030 DECIM=1, constant input 16'h7FFF with sum(COEF) > 1.0 -> outputs saturate at 16'h7FFF; constant 16'h8000 -> outputs saturate at 16'h8000.
REQ-031 Two valid samples 3 cycles apart -> o_overrun=1 from the second edge, second sample absent from the delay line, exactly one output.
REQ-032 DECIM=2, 32 samples spaced 20 cycles apart -> exactly 16 outputs, the first following sample 2.
REQ-033 i_reset asserted 5 cycles into MAC and released -> no o_out_valid, all outputs 0, the next impulse reproduces REQ-029.

Source files
------------

// File: rtl/cic_comp_pkg.sv
// Shared constants, coefficient table and FSM state type for the CIC compensation FIR.
package cic_comp_pkg;

  localparam int unsigned NUM_TAPS   = 16;
  localparam int unsigned COEF_WIDTH = 16;

  // Q1.15 inverse-sinc compensation taps; symmetric, DC gain ~1.52.
  localparam logic signed [COEF_WIDTH-1:0] COEF [NUM_TAPS] = '{
    -16'sd101,  16'sd221,  -16'sd480,  16'sd900,
    -16'sd1600, 16'sd3000,  16'sd9000, 16'sd14000,
     16'sd14000, 16'sd9000, 16'sd3000, -16'sd1600,
     16'sd900,  -16'sd480,  16'sd221,  -16'sd101
  };

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    ROUND
  } state_t;

endpackage

// File: rtl/cic_comp_fir_round_sat.sv
// Round-half-up by 2^(SHIFT-1), arithmetic right shift, saturate to OUT_W signed.
module round_sat #(
  parameter int unsigned IN_W  = 36,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned SHIFT = 15
) (
  input  logic signed [IN_W-1:0]  i_data,
  output logic signed [OUT_W-1:0] o_data
);

  localparam int unsigned EXT_W = IN_W + 1;

  localparam logic signed [EXT_W-1:0] BIAS =
    {{(EXT_W-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
  localparam logic signed [EXT_W-1:0] MAXV =
    {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] MINV =
    {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [EXT_W-1:0] w_ext;
  logic signed [EXT_W-1:0] w_biased;
  logic signed [EXT_W-1:0] w_shifted;

  // Extend by one bit so the rounding bias can never wrap, then clamp.
  always_comb begin
    w_ext     = {i_data[IN_W-1], i_data};
    w_biased  = w_ext + BIAS;
    w_shifted = w_biased >>> SHIFT;
    if (w_shifted > MAXV) begin
      o_data = MAXV[OUT_W-1:0];
    end else if (w_shifted < MINV) begin
      o_data = MINV[OUT_W-1:0];
    end else begin
      o_data = w_shifted[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/cic_comp_fir.sv
// 16-tap serial-MAC compensation FIR following a CIC decimator, optional 2x decimation.
module cic_comp_fir
  import cic_comp_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DECIM = 1
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic signed [WIDTH-1:0] i_in_data,
  input  logic                    i_in_valid,
  output logic signed [WIDTH-1:0] o_out_data,
  output logic                    o_out_valid,
  output logic                    o_overrun
);

  localparam int unsigned PROD_W = WIDTH + COEF_WIDTH;
  localparam int unsigned ACC_W  = WIDTH + COEF_WIDTH + 4;
  localparam int unsigned K_W    = $clog2(NUM_TAPS) + 1;

  state_t                   r_state;
  logic signed [WIDTH-1:0]  r_delay [NUM_TAPS];
  logic [K_W-1:0]           r_k;
  logic                     r_phase;
  logic signed [PROD_W-1:0] r_prod;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [WIDTH-1:0]  r_out_data;
  logic                     r_out_valid;
  logic                     r_overrun;

  logic [K_W-2:0]           w_tap;
  logic signed [PROD_W-1:0] w_prod;
  logic                     w_phase_wrap;
  logic                     w_accept;
  logic                     w_start;
  logic signed [WIDTH-1:0]  w_rounded;

  assign w_tap        = r_k[K_W-2:0];
  assign w_prod       = r_delay[w_tap] * COEF[w_tap];
  assign w_phase_wrap = (DECIM == 1) || r_phase;
  assign w_accept     = i_in_valid && (r_state == IDLE);
  assign w_start      = w_accept && w_phase_wrap;

  round_sat #(
    .IN_W  (ACC_W),
    .OUT_W (WIDTH),
    .SHIFT (COEF_WIDTH - 1)
  ) u_round_sat (
    .i_data (r_acc),
    .o_data (w_rounded)
  );

  // Sample intake, delay line, phase counter and the IDLE/MAC/ROUND sequencer.
  // The product is registered, so MAC runs one extra cycle (k=16) to drain the
  // last product into the accumulator before ROUND.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= IDLE;
      for (int unsigned k = 0; k < NUM_TAPS; k++) begin
        r_delay[k] <= '0;
      end
      r_k         <= '0;
      r_phase     <= 1'b0;
      r_prod      <= '0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;

      if (w_accept) begin
        for (int unsigned k = NUM_TAPS - 1; k > 0; k--) begin
          r_delay[k] <= r_delay[k-1];
        end
        r_delay[0] <= i_in_data;
        r_phase    <= w_phase_wrap ? 1'b0 : 1'b1;
      end else if (i_in_valid) begin
        r_overrun <= 1'b1;
      end

      unique case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= MAC;
            r_acc   <= '0;
            r_k     <= '0;
          end
        end
        MAC: begin
          if (r_k != K_W'(NUM_TAPS)) begin
            r_prod <= w_prod;
          end
          if (r_k != '0) begin
            r_acc <= r_acc + ACC_W'(r_prod);
          end
          if (r_k == K_W'(NUM_TAPS)) begin
            r_state <= ROUND;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        ROUND: begin
          r_out_data  <= w_rounded;
          r_out_valid <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_cic_comp_fir.sv
// Self-checking bench: DECIM=1 and DECIM=2 instances share stimulus and are
// compared every cycle against a sample-level reference model.
module tb_cic_comp_fir;

  localparam int LAT = 18;

  localparam int TB_COEF [16] = '{
    -101, 221, -480, 900, -1600, 3000, 9000, 14000,
    14000, 9000, 3000, -1600, 900, -480, 221, -101
  };
  localparam int IMP_EXP [16] = '{
    -50, 111, -240, 450, -800, 1500, 4500, 7000,
    7000, 4500, 1500, -800, 450, -240, 111, -50
  };

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [15:0] din = '0;
  logic vin = 1'b0;

  logic signed [15:0] d0, d1;
  logic v0, v1, o0, o1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cic_comp_fir #(.WIDTH(16), .DECIM(1)) u_dut1 (
    .i_clock(clk), .i_reset(rst), .i_in_data(din), .i_in_valid(vin),
    .o_out_data(d0), .o_out_valid(v0), .o_overrun(o0)
  );

  cic_comp_fir #(.WIDTH(16), .DECIM(2)) u_dut2 (
    .i_clock(clk), .i_reset(rst), .i_in_data(din), .i_in_valid(vin),
    .o_out_data(d1), .o_out_valid(v1), .o_overrun(o1)
  );

  task automatic chk(input string name, input int inst, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s inst%0d t=%0t actual=%0d required=%0d", name, inst, $time, act, exp);
    end
  endtask

  // ---------------- reference model (per-sample arithmetic) ----------------
  int ec = 0;
  int m_dl    [2][16];
  int m_phase [2];
  int m_busy  [2];
  bit m_pend  [2];
  int m_due   [2];
  int m_val   [2];
  int m_last  [2];
  bit m_expv  [2];
  bit m_ovr   [2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        for (int k = 0; k < 16; k++) m_dl[i][k] = 0;
        m_phase[i] = 0;
        m_busy[i]  = -1000;
        m_pend[i]  = 1'b0;
        m_last[i]  = 0;
        m_expv[i]  = 1'b0;
        m_ovr[i]   = 1'b0;
      end
    end else begin
      ec++;
      for (int i = 0; i < 2; i++) begin
        m_expv[i] = 1'b0;
        if (m_pend[i] && ec == m_due[i]) begin
          m_last[i] = m_val[i];
          m_expv[i] = 1'b1;
          m_pend[i] = 1'b0;
        end
        if (vin) begin
          if (ec > m_busy[i]) begin
            for (int k = 15; k > 0; k--) m_dl[i][k] = m_dl[i][k-1];
            m_dl[i][0] = int'(din);
            if (m_phase[i] == i) begin
              longint s;
              s = 0;
              for (int k = 0; k < 16; k++) s += longint'(m_dl[i][k]) * TB_COEF[k];
              s = (s + 16384) >>> 15;
              if (s > 32767) s = 32767;
              if (s < -32768) s = -32768;
              m_phase[i] = 0;
              m_val[i]   = int'(s);
              m_pend[i]  = 1'b1;
              m_due[i]   = ec + LAT;
              m_busy[i]  = ec + LAT;
            end else begin
              m_phase[i]++;
            end
          end else begin
            m_ovr[i] = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare + output capture ----------------
  int q_d0[$], q_e0[$], q_d1[$], q_e1[$];

  always @(negedge clk) begin
    chk("valid",   0, int'(v0), int'(m_expv[0]));
    chk("data",    0, int'(d0), m_last[0]);
    chk("overrun", 0, int'(o0), int'(m_ovr[0]));
    chk("valid",   1, int'(v1), int'(m_expv[1]));
    chk("data",    1, int'(d1), m_last[1]);
    chk("overrun", 1, int'(o1), int'(m_ovr[1]));
    if (v0) begin q_d0.push_back(int'(d0)); q_e0.push_back(ec); end
    if (v1) begin q_d1.push_back(int'(d1)); q_e1.push_back(ec); end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send(input logic signed [15:0] x);
    vin = 1'b1;
    din = x;
    tick(1);
    vin = 1'b0;
    din = '0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
  endtask

  task automatic clear_caps;
    q_d0.delete(); q_e0.delete(); q_d1.delete(); q_e1.delete();
  endtask

  task automatic run_impulse;
    int s_edge [16];
    do_reset();
    clear_caps();
    for (int n = 0; n < 16; n++) begin
      send((n == 0) ? 16'sh4000 : 16'sh0000);
      s_edge[n] = ec;
      tick(19);
    end
    tick(30);
    chk("imp_count", 0, q_d0.size(), 16);
    chk("imp_count", 1, q_d1.size(), 8);
    for (int k = 0; k < 16; k++) begin
      if (k < q_d0.size()) begin
        chk("imp_value", 0, q_d0[k], IMP_EXP[k]);
        chk("imp_latency", 0, q_e0[k] - s_edge[k], 18);
      end
    end
  endtask

  initial begin
    int e_s2;
    tick(3);
    chk("rst_data", 0, int'(d0), 0);
    chk("rst_valid", 0, int'(v0), 0);
    chk("rst_ovr", 0, int'(o0), 0);
    chk("rst_data", 1, int'(d1), 0);
    rst = 1'b0;

    // long idle: nothing should come out
    clear_caps();
    tick(2000);
    chk("idle_pulses", 0, q_d0.size(), 0);
    chk("idle_pulses", 1, q_d1.size(), 0);
    chk("idle_ovr", 0, int'(o0), 0);

    // impulse response
    run_impulse();

    // saturation both rails
    do_reset();
    clear_caps();
    repeat (20) begin send(16'sh7FFF); tick(19); end
    tick(30);
    chk("sat_pos_count", 0, q_d0.size(), 20);
    if (q_d0.size() > 0) chk("sat_pos", 0, q_d0[q_d0.size()-1], 32767);
    if (q_d1.size() > 0) chk("sat_pos", 1, q_d1[q_d1.size()-1], 32767);
    clear_caps();
    repeat (20) begin send(16'sh8000); tick(19); end
    tick(30);
    if (q_d0.size() > 0) chk("sat_neg", 0, q_d0[q_d0.size()-1], -32768);
    if (q_d1.size() > 0) chk("sat_neg", 1, q_d1[q_d1.size()-1], -32768);

    // overrun: second sample 3 cycles after the first is dropped
    do_reset();
    clear_caps();
    send(16'sd1000);
    tick(2);
    send(16'sd2000);
    chk("ovr_set", 0, int'(o0), 1);
    chk("ovr_set", 1, int'(o1), 0);
    tick(40);
    chk("ovr_outputs", 0, q_d0.size(), 1);
    if (q_d0.size() > 0) chk("ovr_first", 0, q_d0[0], -3);
    send(16'sd0);
    tick(40);
    chk("ovr_outputs2", 0, q_d0.size(), 2);
    if (q_d0.size() > 1) chk("ovr_dropped", 0, q_d0[1], 7);
    chk("ovr_sticky", 0, int'(o0), 1);

    // DECIM=2 output count and first-output timing
    do_reset();
    clear_caps();
    e_s2 = 0;
    for (int n = 0; n < 32; n++) begin
      send(16'($urandom));
      if (n == 1) e_s2 = ec;
      tick(19);
    end
    tick(30);
    chk("dec2_count", 1, q_d1.size(), 16);
    chk("dec1_count", 0, q_d0.size(), 32);
    if (q_e1.size() > 0) chk("dec2_first", 1, q_e1[0] - e_s2, 18);

    // reset in the middle of MAC aborts the computation
    send(16'sh4000);
    tick(5);
    rst = 1'b1;
    tick(2);
    chk("abort_data", 0, int'(d0), 0);
    chk("abort_valid", 0, int'(v0), 0);
    rst = 1'b0;
    clear_caps();
    tick(40);
    chk("abort_pulses", 0, q_d0.size(), 0);
    chk("abort_pulses", 1, q_d1.size(), 0);
    run_impulse();

    // random traffic including overruns
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      vin = ($urandom_range(0, 99) < 30);
      din = 16'($urandom);
      tick(1);
    end
    vin = 1'b0;
    din = '0;
    tick(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
